// File: rtl/am_similarity_accumulator_if.sv
// Query handshake and associative-memory read bus for am_similarity_accumulator.
// The master side drives query chunks and returns AM read data one cycle after am_ren.
interface am_similarity_accumulator_if #(
  parameter int CHUNK_W = 100
);
  logic               q_valid;
  logic               q_ready;
  logic [CHUNK_W-1:0] q_chunk;
  logic               am_ren;
  logic [10:0]        am_addr;
  logic [CHUNK_W-1:0] am_rdata;

  modport master (
    output q_valid, q_chunk, am_rdata,
    input  q_ready, am_ren, am_addr
  );

  modport slave (
    input  q_valid, q_chunk, am_rdata,
    output q_ready, am_ren, am_addr
  );
endinterface

// File: rtl/am_similarity_accumulator.sv
// Streams query chunks, reads every class chunk from AM and accumulates per-class popcount scores.
// Optional feature macro AM_SIM_HAMMING_EN: score matching bits instead of sparse overlap.
module am_similarity_accumulator #(
  parameter int NUM_CLASSES = 26,
  parameter int CHUNK_W     = 100,
  parameter int NUM_CHUNKS  = 50
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  am_similarity_accumulator_if.slave  bus,
  output logic [12:0]                 similarity_values [0:NUM_CLASSES-1],
  output logic                        inferring_class,
  output logic                        busy
);

  // state  | meaning
  // IDLE   | waiting for start; scores hold last result
  // WAIT_Q | q_ready high, waiting for the next query chunk
  // READ   | one AM read per class for the latched chunk
  // DRAIN  | accumulate the last class read, advance chunk
  // DONE   | one-cycle inferring_class pulse
  typedef enum logic [2:0] {IDLE, WAIT_Q, READ, DRAIN, DONE} state_t;

  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int CHK_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int INC_W = $clog2(CHUNK_W + 1);

  state_t             state_q;
  logic [CLS_W-1:0]   cls_q;
  logic [CLS_W-1:0]   rd_cls_q;
  logic               rd_pend_q;
  logic [CHK_W-1:0]   chunk_q;
  logic [CHUNK_W-1:0] query_q;
  logic [12:0]        scores_q [0:NUM_CLASSES-1];
  logic               q_ready_q;
  logic               am_ren_q;
  logic [10:0]        am_addr_q;
  logic               infer_q;
  logic               busy_q;

  logic [CHUNK_W-1:0] match;
  logic [INC_W-1:0]   score_inc_d;

`ifdef AM_SIM_HAMMING_EN
  assign match = ~(query_q ^ bus.am_rdata);
`else
  assign match = query_q & bus.am_rdata;
`endif

  always_comb begin
    score_inc_d = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      score_inc_d = score_inc_d + INC_W'(match[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cls_q     <= '0;
      rd_cls_q  <= '0;
      rd_pend_q <= 1'b0;
      chunk_q   <= '0;
      query_q   <= '0;
      q_ready_q <= 1'b0;
      am_ren_q  <= 1'b0;
      am_addr_q <= '0;
      infer_q   <= 1'b0;
      busy_q    <= 1'b0;
      for (int k = 0; k < NUM_CLASSES; k++) scores_q[k] <= '0;
    end else begin
      // Read data lags am_ren by one cycle; remember which class it belongs to.
      rd_pend_q <= am_ren_q;
      rd_cls_q  <= cls_q;
      if (rd_pend_q) begin
        scores_q[rd_cls_q] <= scores_q[rd_cls_q] + 13'(score_inc_d);
      end

      unique case (state_q)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NUM_CLASSES; k++) scores_q[k] <= '0;
            chunk_q   <= '0;
            q_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= WAIT_Q;
          end
        end
        WAIT_Q: begin
          if (bus.q_valid && q_ready_q) begin
            query_q   <= bus.q_chunk;
            q_ready_q <= 1'b0;
            am_ren_q  <= 1'b1;
            am_addr_q <= 11'(chunk_q);
            cls_q     <= '0;
            state_q   <= READ;
          end
        end
        READ: begin
          if (cls_q == CLS_W'(NUM_CLASSES - 1)) begin
            am_ren_q  <= 1'b0;
            am_addr_q <= '0;
            state_q   <= DRAIN;
          end else begin
            cls_q     <= cls_q + CLS_W'(1);
            am_addr_q <= am_addr_q + 11'(NUM_CHUNKS);
          end
        end
        DRAIN: begin
          if (chunk_q == CHK_W'(NUM_CHUNKS - 1)) begin
            infer_q <= 1'b1;
            state_q <= DONE;
          end else begin
            chunk_q   <= chunk_q + CHK_W'(1);
            q_ready_q <= 1'b1;
            state_q   <= WAIT_Q;
          end
        end
        DONE: begin
          infer_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.q_ready       = q_ready_q;
  assign bus.am_ren        = am_ren_q;
  assign bus.am_addr       = am_addr_q;
  assign similarity_values = scores_q;
  assign inferring_class   = infer_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_am_similarity_accumulator.sv
// Scoreboard bench for am_similarity_accumulator: stimulus pushes expected AM addresses and
// final scores; a negedge monitor pops and compares whenever am_ren or inferring_class is seen.
module tb_am_similarity_accumulator;
  localparam int NCL = 26;
  localparam int CW  = 100;
  localparam int NCH = 50;

  typedef struct {
    int sc [NCL];
    int done_cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [12:0] sim [0:NCL-1];
  logic        inferring_class;
  logic        busy;

  am_similarity_accumulator_if #(.CHUNK_W(CW)) bif ();

  am_similarity_accumulator #(
    .NUM_CLASSES(NCL), .CHUNK_W(CW), .NUM_CHUNKS(NCH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .bus               (bif),
    .similarity_values (sim),
    .inferring_class   (inferring_class),
    .busy              (busy)
  );

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   test_id  = 0;
  int   exp_addr_q [$];
  exp_t exp_sc_q [$];
  exp_t mon_e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // AM contents per test: 0 = class 5 all ones; 1 = class k has its low k bits set; 2 = all zero.
  function automatic logic [CW-1:0] am_word(input int addr);
    logic [CW-1:0] w;
    int k;
    w = '0;
    k = addr / NCH;
    case (test_id)
      0: if (k == 5) w = '1;
      1: for (int i = 0; i < k; i++) w[i] = 1'b1;
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [CW-1:0] q_word(input int c);
    logic [CW-1:0] w;
    w = '0;
    case (test_id)
      0: w = '1;
      1: if (c < 10) w[3:0] = 4'hF; else w[1:0] = 2'b11;
      default: w = '0;
    endcase
    return w;
  endfunction

  // Hand-derived per-chunk scores: overlap of low-b query bits with low-k class bits is min(k,b),
  // matching bits are 100-|k-b|.
  function automatic int exp_score(input int tid, input int k, input int nch);
    int s;
    int b;
    s = 0;
    for (int c = 0; c < nch; c++) begin
      case (tid)
        0: s += (k == 5) ? 100 : 0;
        1: begin
          b = (c < 10) ? 4 : 2;
`ifdef AM_SIM_HAMMING_EN
          s += 100 - ((k > b) ? k - b : b - k);
`else
          s += (k < b) ? k : b;
`endif
        end
        default: begin
`ifdef AM_SIM_HAMMING_EN
          s += 100;
`else
          s += 0;
`endif
        end
      endcase
    end
    return s;
  endfunction

  // AM model: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    if (bif.am_ren) bif.am_rdata <= am_word(int'(bif.am_addr));
    else            bif.am_rdata <= '1;
  end

  always @(negedge clk) begin
    if (bif.am_ren) begin
      if (exp_addr_q.size() == 0) fail_now("am_ren_unexpected");
      else check("am_addr", int'(bif.am_addr), exp_addr_q.pop_front());
    end
    if (inferring_class) begin
      if (exp_sc_q.size() == 0) fail_now("inferring_class_unexpected");
      else begin
        mon_e = exp_sc_q.pop_front();
        check("infer_cycle", cyc, mon_e.done_cyc);
        for (int k = 0; k < NCL; k++) check("final_score", int'(sim[k]), mon_e.sc[k]);
      end
    end
  end

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  endtask

  task automatic send_chunk(input int c, output int hs);
    int n;
    n = 0;
    bif.q_valid = 1'b1;
    bif.q_chunk = q_word(c);
    while (!bif.q_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bif.q_ready) begin
      fail_now("q_ready_timeout");
      finish_run();
    end
    for (int k = 0; k < NCL; k++) exp_addr_q.push_back(k * NCH + c);
    @(posedge clk); #1;
    hs = cyc;
    bif.q_valid = 1'b0;
  endtask

  task automatic run_query(input int rst_chunk, input bit extra_start, input bit stall);
    exp_t e;
    int   hs;
    int   n;
    hs = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int c = 0; c < NCH; c++) begin
      if (stall && c == 3) begin
        n = 0;
        while (!bif.q_ready && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        for (int i = 0; i < 10; i++) begin
          @(posedge clk); #1;
          check("stall_q_ready", bif.q_ready, 1);
          check("stall_am_ren", bif.am_ren, 0);
          check("stall_busy", busy, 1);
        end
        for (int k = 0; k < NCL; k++) check("stall_score", int'(sim[k]), exp_score(test_id, k, 3));
      end
      send_chunk(c, hs);
      if (c == rst_chunk) begin
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_addr_q.delete();
        check("rst_busy", busy, 0);
        check("rst_q_ready", bif.q_ready, 0);
        check("rst_am_ren", bif.am_ren, 0);
        check("rst_am_addr", int'(bif.am_addr), 0);
        check("rst_infer", inferring_class, 0);
        for (int k = 0; k < NCL; k++) check("rst_score", int'(sim[k]), 0);
        repeat (2) begin @(posedge clk); #1; end
        for (int k = 0; k < NCL; k++) check("rst_discard_score", int'(sim[k]), 0);
        return;
      end
      if (extra_start && c == 10) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    for (int k = 0; k < NCL; k++) e.sc[k] = exp_score(test_id, k, NCH);
    e.done_cyc = hs + 27;
    exp_sc_q.push_back(e);
    while (cyc < hs + 27) begin @(posedge clk); #1; end
    if (extra_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_in_done_busy", busy, 0);
      check("start_in_done_q_ready", bif.q_ready, 0);
    end
    repeat (4) begin @(posedge clk); #1; end
    check("infer_seen", exp_sc_q.size(), 0);
    check("hold_score5", int'(sim[5]), exp_score(test_id, 5, NCH));
    check("hold_score4", int'(sim[4]), exp_score(test_id, 4, NCH));
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    bif.q_valid = 1'b0;
    bif.q_chunk = '0;
    repeat (3) begin @(posedge clk); #1; end
    check("init_busy", busy, 0);
    check("init_q_ready", bif.q_ready, 0);
    check("init_am_ren", bif.am_ren, 0);
    check("init_am_addr", int'(bif.am_addr), 0);
    check("init_infer", inferring_class, 0);
    for (int k = 0; k < NCL; k++) check("init_score", int'(sim[k]), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    test_id = 0; run_query(-1, 1'b0, 1'b0);
    test_id = 1; run_query(-1, 1'b0, 1'b1);
    test_id = 1; run_query(20, 1'b0, 1'b0);
    test_id = 1; run_query(-1, 1'b1, 1'b0);
    test_id = 2; run_query(-1, 1'b0, 1'b0);

    check("addr_queue_empty", exp_addr_q.size(), 0);
    finish_run();
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end
endmodule

// File: doc/am_similarity_accumulator.md
AM_SIMILARITY_ACCUMULATOR -- requirements
Module: am_similarity_accumulator

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 26, number of class hypervectors in associative memory (AM).
REQ-002 SHALL have parameter CHUNK_W, default 100, query/class chunk width in bits.
REQ-003 SHALL have parameter NUM_CHUNKS, default 50, chunks per hypervector (5000 dims total).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a new query.
REQ-007 SHALL have port q_valid  input  1  query chunk valid.
REQ-008 SHALL have port q_ready  output  1  block accepts query chunk.
REQ-009 SHALL have port q_chunk  input  CHUNK_W  query chunk, chunk 0 first.
REQ-010 SHALL have port am_ren  output  1  AM read enable.
REQ-011 SHALL have port am_addr  output  11  AM address = class*NUM_CHUNKS + chunk.
REQ-012 SHALL have port am_rdata  input  CHUNK_W  AM read data, valid exactly one cycle after am_ren.
REQ-013 SHALL have port similarity_values  output  13 x NUM_CLASSES  unpacked array [0:NUM_CLASSES-1] of per-class scores.
REQ-014 SHALL have port inferring_class  output  1  one-cycle pulse, scores final; drives the tree comparator enable.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_Q, READ, DRAIN, DONE.
REQ-017 IDLE: start=1 SHALL clear all scores and chunk counter to 0, next state WAIT_Q; start outside IDLE SHALL be ignored.
REQ-018 WAIT_Q: q_ready SHALL be 1 (0 in all other states); on q_valid&q_ready the chunk SHALL be latched, next state READ.
REQ-019 READ: SHALL last exactly NUM_CLASSES cycles; cycle k asserts am_ren=1, am_addr=k*NUM_CHUNKS+chunk, k=0..NUM_CLASSES-1; am_ren=0 outside READ.
REQ-020 Cycle after each read, score[k] SHALL be incremented by popcount(latched_query & am_rdata).
REQ-021 DRAIN: single cycle accumulating the last class; next state DONE if chunk==NUM_CHUNKS-1, else chunk+1 and WAIT_Q.
REQ-022 DONE: inferring_class=1 for exactly this cycle, next state IDLE; start in DONE SHALL be ignored.
REQ-023 Latency: handshake in cycle t -> READ t+1..t+NUM_CLASSES, DRAIN t+NUM_CLASSES+1; for last chunk inferring_class at t+NUM_CLASSES+2 (t+28 default).
REQ-024 Scores SHALL be 13-bit unsigned; max 5000 cannot overflow; no saturation logic.
REQ-025 similarity_values SHALL hold final values after DONE until next accepted start.
REQ-026 q_valid held low in WAIT_Q SHALL stall indefinitely with no AM reads and no score change.

Reset
REQ-027 rst=1 at any clock edge, including mid-READ/DRAIN, SHALL force IDLE; all scores, chunk counter and latched query 0; q_ready, am_ren, inferring_class, busy 0; am_addr 0.
REQ-028 AM data returning the cycle after reset SHALL be discarded.

Configuration
REQ-029 Macro AM_SIM_HAMMING_EN: defined -> increment SHALL be popcount(~(latched_query ^ am_rdata)) (matching bits); undefined -> popcount(latched_query & am_rdata) (sparse overlap).

Verification
REQ-030 Query all-ones, class k chunks all-ones for k=5, all-zero else -> score[5]=5000, others 0, inferring_class one cycle at handshake_last+28.
REQ-031 Single chunk handshake at cycle t -> am_addr 0,50,...,1250 at t+1..t+26 (chunk 0); chunk 3 -> 3,53,...,1253.
REQ-032 q_valid low 10 cycles in WAIT_Q -> q_ready stays 1, am_ren 0, scores unchanged, busy 1.
REQ-033 rst=1 during READ of chunk 20 -> next cycle IDLE, all scores 0, busy 0; later start+full query gives correct scores.
REQ-034 start pulsed during READ and DONE -> no effect; scores match run without extra pulses.
REQ-035 With AM_SIM_HAMMING_EN, query all-zero vs class all-zero -> score 5000; without it -> score 0.
